// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART rate codes, divisor function, FSM states and oversample constants
package uart_pkg;

    localparam int unsigned OVERSAMPLE = 16;
    localparam logic [3:0]  SAMPLE_A   = 4'd7;
    localparam logic [3:0]  SAMPLE_B   = 4'd8;
    localparam logic [3:0]  SAMPLE_C   = 4'd9;
    localparam logic [3:0]  TICK_LAST  = 4'd15;

    typedef enum logic [2:0] {
        RATE_9600   = 3'd0,
        RATE_19200  = 3'd1,
        RATE_38400  = 3'd2,
        RATE_57600  = 3'd3,
        RATE_115200 = 3'd4
    } rate_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

    // Unused codes 5..7 fall back to 9600 so a stray setting still gives a usable link.
    function automatic logic [15:0] baud_divisor(input int unsigned clk_freq, input logic [2:0] baud_set);
        int unsigned baud;
        case (baud_set)
            RATE_19200:  baud = 19200;
            RATE_38400:  baud = 38400;
            RATE_57600:  baud = 57600;
            RATE_115200: baud = 115200;
            default:     baud = 9600;
        endcase
        return 16'(clk_freq / (OVERSAMPLE * baud));
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// rtl/uart_baud_tick.sv - 16x oversample tick divider, held at zero while clr is high
module uart_baud_tick (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic [15:0] div,
    output logic        tick
);

    logic [15:0] cnt;
    logic        wrap;

    assign wrap = (cnt == div - 16'd1);
    assign tick = wrap && !clr;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (wrap) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 16'd1;
        end
    end

endmodule

// File: rtl/uart_rx_ram_loader.sv
// rtl/uart_rx_ram_loader.sv - 8N1 UART receiver that writes each good byte into RAM at an auto-incrementing address
module uart_rx_ram_loader
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ = 50_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rs232_rx,
    input  logic [2:0] baud_set,
    input  logic       load_en,
    input  logic       addr_clr,
    output logic [7:0] rx_data,
    output logic       rx_done,
    output logic       frame_err,
    output logic       rx_busy,
    output logic       w_en,
    output logic [7:0] addr,
    output logic [7:0] data_in
);

    rx_state_t   state, next_state;
    logic        rx_meta, rx_sync, rx_prev, fall;
    logic [15:0] div_sel, div_q;
    logic        tick, tick_clr;
    logic [3:0]  tick_cnt;
    logic [2:0]  bit_cnt;
    logic [1:0]  samp;
    logic [7:0]  shift;
    logic        maj, at_mid, at_end, frame_good, frame_bad;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rs232_rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    assign fall    = rx_prev && !rx_sync;
    assign div_sel = baud_divisor(CLK_FREQ, baud_set);

    uart_baud_tick u_baud_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (tick_clr),
        .div  (div_q),
        .tick (tick)
    );

    // Third vote comes straight from the line on the tick-9 sample.
    assign maj    = (samp[0] & samp[1]) | (samp[0] & rx_sync) | (samp[1] & rx_sync);
    assign at_mid = tick && (tick_cnt == SAMPLE_C);
    assign at_end = tick && (tick_cnt == TICK_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:  if (fall) next_state = START;
            START: begin
                if (at_mid && maj)  next_state = IDLE;
                else if (at_end)    next_state = DATA;
            end
            DATA:  if (at_end && bit_cnt == 3'd7) next_state = STOP;
            STOP:  if (at_mid) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        tick_clr   = (state == IDLE);
        rx_busy    = (state != IDLE);
        frame_good = (state == STOP) && at_mid && maj;
        frame_bad  = (state == STOP) && at_mid && !maj;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q    <= baud_divisor(CLK_FREQ, 3'd0);
            tick_cnt <= '0;
            bit_cnt  <= '0;
            samp     <= '0;
            shift    <= '0;
        end else if (state == IDLE) begin
            tick_cnt <= '0;
            bit_cnt  <= '0;
            if (fall) div_q <= div_sel;
        end else if (tick) begin
            tick_cnt <= tick_cnt + 4'd1;
            if (tick_cnt == SAMPLE_A) samp[0] <= rx_sync;
            if (tick_cnt == SAMPLE_B) samp[1] <= rx_sync;
            if (state == DATA && at_mid) shift <= {maj, shift[7:1]};
            if (state == DATA && at_end) bit_cnt <= bit_cnt + 3'd1;
        end
    end

    // addr advances the cycle after the w_en strobe; a clear always wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_done   <= 1'b0;
            frame_err <= 1'b0;
            w_en      <= 1'b0;
            rx_data   <= 8'h00;
            data_in   <= 8'h00;
            addr      <= 8'h00;
        end else begin
            rx_done   <= frame_good;
            frame_err <= frame_bad;
            w_en      <= frame_good && load_en;
            if (frame_good) rx_data <= shift;
            if (frame_good && load_en) data_in <= shift;
            if (addr_clr) begin
                addr <= 8'h00;
            end else if (w_en) begin
                addr <= addr + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_ram_loader.sv
// tb/tb_uart_rx_ram_loader.sv - directed self-checking bench for uart_rx_ram_loader
module tb_uart_rx_ram_loader;

    // Divisors at this clock: 12/6/3/2/1 for rates 0..4
    localparam int unsigned CLK_FREQ = 1_843_200;
    localparam int BIT4 = 16;
    localparam int BIT0 = 192;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rs232_rx = 1'b1;
    logic [2:0] baud_set = 3'd4;
    logic       load_en = 1'b1;
    logic       addr_clr = 1'b0;
    logic [7:0] rx_data, addr, data_in;
    logic       rx_done, frame_err, rx_busy, w_en;

    int n_vec = 0;
    int n_err = 0;
    logic [7:0] wa_q[$];
    logic [7:0] wd_q[$];
    logic [7:0] done_q[$];
    int ferr_cnt = 0;
    int busy_bad = 0;

    uart_rx_ram_loader #(.CLK_FREQ(CLK_FREQ)) dut (
        .clk       (clk),
        .rst       (rst),
        .rs232_rx  (rs232_rx),
        .baud_set  (baud_set),
        .load_en   (load_en),
        .addr_clr  (addr_clr),
        .rx_data   (rx_data),
        .rx_done   (rx_done),
        .frame_err (frame_err),
        .rx_busy   (rx_busy),
        .w_en      (w_en),
        .addr      (addr),
        .data_in   (data_in)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (w_en) begin
            wa_q.push_back(addr);
            wd_q.push_back(data_in);
        end
        if (rx_done) begin
            done_q.push_back(rx_data);
            if (rx_busy) busy_bad++;
        end
        if (frame_err) ferr_cnt++;
    end

    task automatic clear_mon();
        wa_q.delete();
        wd_q.delete();
        done_q.delete();
        ferr_cnt = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop, input int bit_clks);
        rs232_rx = 1'b0;
        repeat (bit_clks) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rs232_rx = b[i];
            repeat (bit_clks) @(negedge clk);
        end
        rs232_rx = stop;
        repeat (bit_clks) @(negedge clk);
        rs232_rx = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle(4);
        n_vec++;
        if ({rx_done, frame_err, rx_busy, w_en} !== 4'b0000) begin
            n_err++; $display("FAIL reset_flags: got %b expected 0000", {rx_done, frame_err, rx_busy, w_en});
        end
        n_vec++;
        if (addr !== 8'h00) begin n_err++; $display("FAIL reset_addr: got %h expected 00", addr); end
        n_vec++;
        if (rx_data !== 8'h00 || data_in !== 8'h00) begin
            n_err++; $display("FAIL reset_data: got %h/%h expected 00/00", rx_data, data_in);
        end
        rst = 1'b0;
        idle(4);
    endtask

    task automatic test_good_frame();
        clear_mon();
        fork
            send_frame(8'hA5, 1'b1, BIT4);
            begin
                idle(5 * BIT4);
                n_vec++;
                if (rx_busy !== 1'b1) begin n_err++; $display("FAIL good_busy_mid: got %b expected 1", rx_busy); end
            end
        join
        idle(10);
        n_vec++;
        if (wa_q.size() != 1) begin
            n_err++; $display("FAIL good_wen_count: got %0d expected 1", wa_q.size());
        end else if (wa_q[0] !== 8'h00 || wd_q[0] !== 8'hA5) begin
            n_err++; $display("FAIL good_write: got addr %h data %h expected 00 A5", wa_q[0], wd_q[0]);
        end
        n_vec++;
        if (done_q.size() != 1 || rx_data !== 8'hA5) begin
            n_err++; $display("FAIL good_rx_data: got %0d dones rx_data %h expected 1 A5", done_q.size(), rx_data);
        end
        n_vec++;
        if (addr !== 8'h01) begin n_err++; $display("FAIL good_addr_after: got %h expected 01", addr); end
    endtask

    task automatic test_wrap();
        addr_clr = 1'b1;
        idle(1);
        addr_clr = 1'b0;
        idle(1);
        n_vec++;
        if (addr !== 8'h00) begin n_err++; $display("FAIL clr_alone: got %h expected 00", addr); end
        clear_mon();
        for (int i = 0; i < 257; i++) begin
            send_frame((i < 256) ? 8'(i) : 8'h11, 1'b1, BIT4);
        end
        idle(10);
        n_vec++;
        if (wa_q.size() != 257) begin n_err++; $display("FAIL wrap_count: got %0d expected 257", wa_q.size()); end
        for (int j = 0; j < 257 && j < wa_q.size(); j++) begin
            n_vec++;
            if (wa_q[j] !== 8'(j) || wd_q[j] !== ((j < 256) ? 8'(j) : 8'h11)) begin
                n_err++;
                $display("FAIL wrap_write[%0d]: got addr %h data %h expected %h %h", j, wa_q[j], wd_q[j],
                         8'(j), (j < 256) ? 8'(j) : 8'h11);
            end
        end
        n_vec++;
        if (addr !== 8'h01) begin n_err++; $display("FAIL wrap_addr_end: got %h expected 01", addr); end
    endtask

    task automatic test_frame_err();
        logic [7:0] a;
        a = addr;
        clear_mon();
        send_frame(8'h3C, 1'b0, BIT4);
        idle(3 * BIT4);
        n_vec++;
        if (ferr_cnt != 1 || wa_q.size() != 0 || done_q.size() != 0) begin
            n_err++; $display("FAIL ferr_pulses: got ferr %0d wen %0d done %0d expected 1 0 0",
                              ferr_cnt, wa_q.size(), done_q.size());
        end
        n_vec++;
        if (addr !== a) begin n_err++; $display("FAIL ferr_addr: got %h expected %h", addr, a); end
        send_frame(8'h5A, 1'b1, BIT4);
        idle(10);
        n_vec++;
        if (wa_q.size() != 1) begin
            n_err++; $display("FAIL ferr_next_count: got %0d expected 1", wa_q.size());
        end else if (wa_q[0] !== a || wd_q[0] !== 8'h5A) begin
            n_err++; $display("FAIL ferr_next_write: got %h %h expected %h 5A", wa_q[0], wd_q[0], a);
        end
        n_vec++;
        if (addr !== a + 8'd1) begin n_err++; $display("FAIL ferr_next_addr: got %h expected %h", addr, a + 8'd1); end
    endtask

    task automatic test_glitch();
        clear_mon();
        rs232_rx = 1'b0;
        idle(5);
        n_vec++;
        if (rx_busy !== 1'b1) begin n_err++; $display("FAIL glitch_busy_start: got %b expected 1", rx_busy); end
        rs232_rx = 1'b1;
        idle(40);
        n_vec++;
        if (rx_busy !== 1'b0) begin n_err++; $display("FAIL glitch_busy_end: got %b expected 0", rx_busy); end
        n_vec++;
        if (ferr_cnt != 0 || wa_q.size() != 0 || done_q.size() != 0) begin
            n_err++; $display("FAIL glitch_outputs: got ferr %0d wen %0d done %0d expected 0 0 0",
                              ferr_cnt, wa_q.size(), done_q.size());
        end
    endtask

    task automatic test_load_en();
        logic [7:0] a;
        a = addr;
        clear_mon();
        load_en = 1'b0;
        send_frame(8'h96, 1'b1, BIT4);
        idle(10);
        load_en = 1'b1;
        n_vec++;
        if (done_q.size() != 1 || rx_data !== 8'h96) begin
            n_err++; $display("FAIL noload_done: got %0d dones rx_data %h expected 1 96", done_q.size(), rx_data);
        end
        n_vec++;
        if (wa_q.size() != 0 || addr !== a) begin
            n_err++; $display("FAIL noload_write: got %0d writes addr %h expected 0 %h", wa_q.size(), addr, a);
        end
    endtask

    task automatic test_addr_clr();
        bit seen;
        addr_clr = 1'b1;
        idle(1);
        addr_clr = 1'b0;
        clear_mon();
        for (int i = 0; i < 7; i++) send_frame(8'h70 + 8'(i), 1'b1, BIT4);
        seen = 1'b0;
        fork
            send_frame(8'h77, 1'b1, BIT4);
            begin
                for (int k = 0; k < 20 * BIT4 && !seen; k++) begin
                    @(negedge clk);
                    if (w_en) begin
                        seen = 1'b1;
                        addr_clr = 1'b1;
                        @(negedge clk);
                        addr_clr = 1'b0;
                    end
                end
            end
        join
        idle(5);
        n_vec++;
        if (!seen) begin n_err++; $display("FAIL clr_wait: got no w_en expected one within budget"); end
        n_vec++;
        if (wa_q.size() != 8) begin
            n_err++; $display("FAIL clr_count: got %0d expected 8", wa_q.size());
        end else if (wa_q[7] !== 8'h07 || wd_q[7] !== 8'h77) begin
            n_err++; $display("FAIL clr_write: got %h %h expected 07 77", wa_q[7], wd_q[7]);
        end
        n_vec++;
        if (addr !== 8'h00) begin n_err++; $display("FAIL clr_addr_after: got %h expected 00", addr); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] b;
        b = 8'hE7;
        clear_mon();
        rs232_rx = 1'b0;
        idle(BIT4);
        for (int i = 0; i < 4; i++) begin
            rs232_rx = b[i];
            idle(BIT4);
        end
        rs232_rx = b[4];
        idle(BIT4 / 2);
        rst = 1'b1;
        idle(2);
        rs232_rx = 1'b1;
        rst = 1'b0;
        idle(3 * BIT4);
        n_vec++;
        if (ferr_cnt != 0 || wa_q.size() != 0 || done_q.size() != 0 || rx_busy !== 1'b0) begin
            n_err++; $display("FAIL rstmid_outputs: got ferr %0d wen %0d done %0d busy %b expected 0 0 0 0",
                              ferr_cnt, wa_q.size(), done_q.size(), rx_busy);
        end
        send_frame(8'h4B, 1'b1, BIT4);
        idle(10);
        n_vec++;
        if (wa_q.size() != 1) begin
            n_err++; $display("FAIL rstmid_next_count: got %0d expected 1", wa_q.size());
        end else if (wa_q[0] !== 8'h00 || wd_q[0] !== 8'h4B || rx_data !== 8'h4B) begin
            n_err++; $display("FAIL rstmid_next: got %h %h %h expected 00 4B 4B", wa_q[0], wd_q[0], rx_data);
        end
    endtask

    task automatic test_rate();
        baud_set = 3'd0;
        clear_mon();
        send_frame(8'hC3, 1'b1, BIT0);
        idle(10);
        n_vec++;
        if (done_q.size() != 1 || rx_data !== 8'hC3) begin
            n_err++; $display("FAIL rate0: got %0d dones rx_data %h expected 1 C3", done_q.size(), rx_data);
        end
        baud_set = 3'd6;
        clear_mon();
        send_frame(8'hC3, 1'b1, BIT0);
        idle(10);
        n_vec++;
        if (done_q.size() != 1 || done_q[0] !== 8'hC3) begin
            n_err++; $display("FAIL rate6: got %0d dones rx_data %h expected 1 C3", done_q.size(), rx_data);
        end
        baud_set = 3'd0;
        clear_mon();
        fork
            send_frame(8'h3E, 1'b1, BIT0);
            begin
                idle(3 * BIT0);
                baud_set = 3'd4;
            end
        join
        idle(10);
        n_vec++;
        if (done_q.size() != 1 || done_q[0] !== 8'h3E || ferr_cnt != 0) begin
            n_err++; $display("FAIL rate_midchange: got %0d dones rx_data %h ferr %0d expected 1 3E 0",
                              done_q.size(), rx_data, ferr_cnt);
        end
        baud_set = 3'd4;
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_wrap();
        test_frame_err();
        test_glitch();
        test_load_en();
        test_addr_clr();
        test_reset_mid();
        test_rate();
        n_vec++;
        if (busy_bad != 0) begin n_err++; $display("FAIL busy_at_done: got %0d expected 0", busy_bad); end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
